// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file writeback port among NREQ requesters.
// Optional WB_ARB_X0_FILTER_EN: suppress integer write enables targeting register 0.
module wb_port_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_reg,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_float,
    input  logic               wb_stall,
    output logic [AW-1:0]      write_reg,
    output logic [DW-1:0]      write_data,
    output logic               regwrite,
    output logic               regwrite_float,
    output logic [2:0]         grant_id
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [AW-1:0] reg_arr  [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [AW-1:0] write_reg_q, write_reg_d;
    logic [DW-1:0] write_data_q, write_data_d;
    logic          regwrite_q, regwrite_d;
    logic          regwrite_float_q, regwrite_float_d;
    logic [2:0]    grant_id_q, grant_id_d;

    logic [PW-1:0] gnt_idx_c;
    logic [PW-1:0] scan_idx_c;
    logic          grant_c;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign reg_arr[i]  = req_reg[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    // Search upward from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        grant_c    = 1'b0;
        gnt_idx_c  = '0;
        scan_idx_c = '0;
        req_ready  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx_c = PW'((32'(rr_ptr_q) + k) % NREQ);
            if (!grant_c && req_valid[scan_idx_c]) begin
                grant_c   = 1'b1;
                gnt_idx_c = scan_idx_c;
            end
        end
        if (wb_stall || !reset_n) begin
            grant_c = 1'b0;
        end
        if (grant_c) begin
            req_ready[gnt_idx_c] = 1'b1;
        end
    end

    always_comb begin
        write_reg_d      = write_reg_q;
        write_data_d     = write_data_q;
        grant_id_d       = grant_id_q;
        rr_ptr_d         = rr_ptr_q;
        regwrite_d       = 1'b0;
        regwrite_float_d = 1'b0;
        if (grant_c) begin
            write_reg_d      = reg_arr[gnt_idx_c];
            write_data_d     = data_arr[gnt_idx_c];
            grant_id_d       = 3'(gnt_idx_c);
            regwrite_float_d = req_float[gnt_idx_c];
`ifdef WB_ARB_X0_FILTER_EN
            regwrite_d       = !req_float[gnt_idx_c] && (reg_arr[gnt_idx_c] != '0);
`else
            regwrite_d       = !req_float[gnt_idx_c];
`endif
            rr_ptr_d         = (gnt_idx_c == PW'(NREQ - 1)) ? '0 : gnt_idx_c + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q         <= '0;
            write_reg_q      <= '0;
            write_data_q     <= '0;
            regwrite_q       <= 1'b0;
            regwrite_float_q <= 1'b0;
            grant_id_q       <= '0;
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            write_reg_q      <= write_reg_d;
            write_data_q     <= write_data_d;
            regwrite_q       <= regwrite_d;
            regwrite_float_q <= regwrite_float_d;
            grant_id_q       <= grant_id_d;
        end
    end

    assign write_reg      = write_reg_q;
    assign write_data     = write_data_q;
    assign regwrite       = regwrite_q;
    assign regwrite_float = regwrite_float_q;
    assign grant_id       = grant_id_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (NREQ=3, DW=32, AW=5).
module tb_wb_port_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;

    logic               clock;
    logic               reset_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_reg;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_float;
    logic               wb_stall;
    logic [AW-1:0]      write_reg;
    logic [DW-1:0]      write_data;
    logic               regwrite;
    logic               regwrite_float;
    logic [2:0]         grant_id;

    int n_checks;
    int n_fail;

    wb_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_reg        (req_reg),
        .req_data       (req_data),
        .req_float      (req_float),
        .wb_stall       (wb_stall),
        .write_reg      (write_reg),
        .write_data     (write_data),
        .regwrite       (regwrite),
        .regwrite_float (regwrite_float),
        .grant_id       (grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d, input logic f);
        req_reg[i*AW +: AW]  = r;
        req_data[i*DW +: DW] = d;
        req_float[i]         = f;
    endtask

    initial begin
        int exp_g;
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_reg   = '0;
        req_data  = '0;
        req_float = '0;
        wb_stall  = 1'b0;

        // Reset state, ready held low even with requests pending
        set_req(0, 5'd10, 32'hA0, 1'b0);
        set_req(1, 5'd11, 32'hA1, 1'b0);
        set_req(2, 5'd12, 32'hA2, 1'b0);
        req_valid = 3'b111;
        tick();
        tick();
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_regwrite", 64'(regwrite), 64'h0);
        check("rst_regwrite_float", 64'(regwrite_float), 64'h0);
        check("rst_write_reg", 64'(write_reg), 64'h0);
        check("rst_write_data", 64'(write_data), 64'h0);
        check("rst_grant_id", 64'(grant_id), 64'h0);

        // Full contention: 0,1,2,0,1,2 with no idle cycle
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_g = i % 3;
            check($sformatf("fc_ready_%0d", i), 64'(req_ready), 64'(1 << exp_g));
            tick();
            check($sformatf("fc_gid_%0d", i), 64'(grant_id), 64'(exp_g));
            check($sformatf("fc_we_%0d", i), 64'(regwrite), 64'h1);
            check($sformatf("fc_reg_%0d", i), 64'(write_reg), 64'(10 + exp_g));
            check($sformatf("fc_data_%0d", i), 64'(write_data), 64'(32'hA0 + exp_g));
            #1;
        end

        // One more grant (0), then stall for 3 cycles
        check("pre_stall_ready", 64'(req_ready), 64'h1);
        tick();
        check("pre_stall_gid", 64'(grant_id), 64'h0);
        wb_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_ready_%0d", i), 64'(req_ready), 64'h0);
            tick();
            check($sformatf("stall_we_%0d", i), 64'({regwrite, regwrite_float}), 64'h0);
            check($sformatf("stall_hold_reg_%0d", i), 64'(write_reg), 64'd10);
            check($sformatf("stall_hold_gid_%0d", i), 64'(grant_id), 64'h0);
            #1;
        end
        wb_stall = 1'b0;
        #1;
        check("resume_ready1", 64'(req_ready), 64'h2);
        tick();
        check("resume_gid1", 64'(grant_id), 64'h1);
        check("resume_ready2", 64'(req_ready), 64'h4);
        tick();
        check("resume_gid2", 64'(grant_id), 64'h2);

        // Single request on requester 1, granted twice regardless of pointer
        set_req(1, 5'd5, 32'h0000_00AA, 1'b0);
        req_valid = 3'b010;
        #1;
        check("single_ready_a", 64'(req_ready), 64'h2);
        tick();
        check("single_we", 64'(regwrite), 64'h1);
        check("single_fwe", 64'(regwrite_float), 64'h0);
        check("single_reg", 64'(write_reg), 64'd5);
        check("single_data", 64'(write_data), 64'hAA);
        check("single_gid", 64'(grant_id), 64'h1);
        check("single_ready_b", 64'(req_ready), 64'h2);
        tick();
        check("single_gid_b", 64'(grant_id), 64'h1);
        req_valid = '0;
        #1;
        check("idle_ready", 64'(req_ready), 64'h0);
        tick();
        check("idle_we", 64'(regwrite), 64'h0);
        check("idle_hold_reg", 64'(write_reg), 64'd5);

        // Float routing on requester 2
        set_req(2, 5'd3, 32'h4060_0000, 1'b1);
        req_valid = 3'b100;
        #1;
        check("float_ready", 64'(req_ready), 64'h4);
        tick();
        check("float_fwe", 64'(regwrite_float), 64'h1);
        check("float_we", 64'(regwrite), 64'h0);
        check("float_reg", 64'(write_reg), 64'd3);
        check("float_data", 64'(write_data), 64'h4060_0000);
        check("float_gid", 64'(grant_id), 64'h2);

        // Integer write to x0 from requester 0 (pointer back at 0)
        set_req(0, 5'd0, 32'd7, 1'b0);
        req_valid = 3'b001;
        #1;
        check("x0_ready", 64'(req_ready), 64'h1);
        tick();
`ifdef WB_ARB_X0_FILTER_EN
        check("x0_we", 64'(regwrite), 64'h0);
`else
        check("x0_we", 64'(regwrite), 64'h1);
`endif
        check("x0_reg", 64'(write_reg), 64'd0);
        check("x0_data", 64'(write_data), 64'd7);
        check("x0_gid", 64'(grant_id), 64'h0);
        req_valid = 3'b011;
        #1;
        check("x0_ptr_adv", 64'(req_ready), 64'h2);

        // Reset mid-stream clears outputs without a clock edge
        tick();
        check("mid_we", 64'(regwrite), 64'h1);
        check("mid_gid", 64'(grant_id), 64'h1);
        req_valid = 3'b111;
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", 64'(regwrite), 64'h0);
        check("mid_rst_fwe", 64'(regwrite_float), 64'h0);
        check("mid_rst_reg", 64'(write_reg), 64'h0);
        check("mid_rst_data", 64'(write_data), 64'h0);
        check("mid_rst_gid", 64'(grant_id), 64'h0);
        check("mid_rst_ready", 64'(req_ready), 64'h0);
        tick();
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'h1);
        tick();
        check("post_rst_gid", 64'(grant_id), 64'h0);
        check("post_rst_we", 64'(regwrite), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
